// File: rtl/cmp_pkg.sv
// Shared definitions for the 2-bit magnitude compare stage: operand width and
// the one-hot result encoding {GT, EQ, LT}.
package cmp_pkg;

    localparam int CMP_W = 2;

    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t CMP_GT   = 3'b100;
    localparam cmp_res_t CMP_EQ   = 3'b010;
    localparam cmp_res_t CMP_LT   = 3'b001;
    // All-zero is the "no result yet" value held during reset.
    localparam cmp_res_t CMP_NONE = 3'b000;

    function automatic cmp_res_t pack_res(input logic gt, input logic eq, input logic lt);
        return {gt, eq, lt};
    endfunction

endpackage

// File: rtl/cmp2_comb.sv
// Combinational unsigned compare of two 2-bit operands; exactly one of gt/eq/lt
// is high for any known input.
module cmp2_comb
    import cmp_pkg::*;
(
    input  logic [CMP_W-1:0] a,
    input  logic [CMP_W-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    logic msb_same;

    assign msb_same = ~(a[1] ^ b[1]);

    // The LSB only decides the result when the MSBs tie.
    assign gt = (a[1] & ~b[1]) | (msb_same & a[0] & ~b[0]);
    assign eq = msb_same & ~(a[0] ^ b[0]);
    assign lt = (~a[1] & b[1]) | (msb_same & ~a[0] & b[0]);

endmodule

// File: rtl/comparator_4b_digital.sv
// Registered 2-bit unsigned magnitude comparator: one-hot {F1=gt, F2=eq, F3=lt}
// with one cycle of latency and an all-zero reset state.
module comparator_4b_digital
    import cmp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic A1,
    input  logic A0,
    input  logic B1,
    input  logic B0,
    output logic F1,
    output logic F2,
    output logic F3
);

    logic     gt;
    logic     eq;
    logic     lt;
    cmp_res_t res;

    cmp2_comb u_cmp2_comb (
        .a  ({A1, A0}),
        .b  ({B1, B0}),
        .gt (gt),
        .eq (eq),
        .lt (lt)
    );

    // Outputs come only from this register, so no input-to-output comb path exists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res <= CMP_NONE;
        end else begin
            res <= pack_res(gt, eq, lt);
        end
    end

    assign F1 = |(res & CMP_GT);
    assign F2 = |(res & CMP_EQ);
    assign F3 = |(res & CMP_LT);

endmodule

// File: tb/tb_comparator_4b_digital.sv
// Randomized self-checking bench for comparator_4b_digital against an arithmetic
// reference model of the unsigned compare.
module tb_comparator_4b_digital;

    logic clk = 1'b0;
    logic rst;
    logic A1, A0, B1, B0;
    logic F1, F2, F3;

    int n_checks = 0;
    int n_pass   = 0;

    comparator_4b_digital dut (
        .clk (clk),
        .rst (rst),
        .A1  (A1),
        .A0  (A0),
        .B1  (B1),
        .B0  (B0),
        .F1  (F1),
        .F2  (F2),
        .F3  (F3)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish (actual timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input int unsigned observed, input int unsigned expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %0b, required %0b", tag, observed, expected);
        end
    endtask

    // Reference: {gt,eq,lt} from plain integer comparison of the operands.
    function automatic int unsigned model(input int a, input int b);
        if (a > b)  return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int unsigned outs();
        return {F1, F2, F3};
    endfunction

    task automatic set_ops(input int a, input int b);
        A1 = a[1]; A0 = a[0];
        B1 = b[1]; B0 = b[0];
    endtask

    task automatic drive_and_check(input int a, input int b, input string tag);
        set_ops(a, b);
        @(posedge clk);
        #1;
        check_val(tag, outs(), model(a, b));
        check_val({tag, "_onehot"}, $countones({F1, F2, F3}), 1);
    endtask

    initial begin
        rst = 1'b1;
        set_ops($urandom_range(3), $urandom_range(3));
        #1;
        check_val("reset_init", outs(), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            set_ops($urandom_range(3), $urandom_range(3));
            check_val("reset_hold", outs(), 0);
        end

        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 16; v++) begin
            drive_and_check(v / 4, v % 4, $sformatf("sweep_%04b", v[3:0]));
        end

        // Inputs change between edges: output must hold until the next rising edge.
        drive_and_check(1, 2, "lat_pre");
        #2;
        set_ops(2, 1);
        #1;
        check_val("lat_hold", outs(), 3'b001);
        @(posedge clk);
        #1;
        check_val("lat_new", outs(), 3'b100);

        for (int i = 0; i < 200; i++) begin
            drive_and_check(int'($urandom_range(3)), int'($urandom_range(3)), "rand");
        end

        drive_and_check(3, 0, "mid_pre");
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_async_clear", outs(), 0);
        #4;
        rst = 1'b0;
        #1;
        check_val("mid_no_restore", outs(), 0);
        @(posedge clk);
        #1;
        check_val("mid_reload", outs(), 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
